// File: rtl/cnn_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cnn_frame_sequencer
// Description : Frame-level controller for the MNIST CNN pipeline. Admits one
//               28x28 image per frame, pulses a datapath clear between frames,
//               checks each layer's output count, runs a streaming argmax over
//               the fc class scores and flags stalled or malformed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_frame_sequencer #(
    parameter int IMG_PIXELS  = 784,
    parameter int CONV1_OUTS  = 676,
    parameter int POOL1_OUTS  = 169,
    parameter int CONV2_OUTS  = 121,
    parameter int POOL2_OUTS  = 25,
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               pix_en,
    output logic               pipe_clear,
    input  logic               valid_out_conv1,
    input  logic               valid_out_maxpool1,
    input  logic               valid_out_conv2,
    input  logic               valid_out_maxpool2,
    input  logic               fc_valid,
    input  logic [SCORE_W-1:0] fc_score,
    output logic               busy,
    output logic [3:0]         prediction,
    output logic               valid_out,
    output logic               error
);

    // One counter width covers the pixel counter and every layer counter,
    // including the expected+1 saturation value.
    localparam int c_MAX_A = (IMG_PIXELS > CONV1_OUTS) ? IMG_PIXELS : CONV1_OUTS;
    localparam int c_MAX_B = (POOL1_OUTS > CONV2_OUTS) ? POOL1_OUTS : CONV2_OUTS;
    localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_MAX   = (c_MAX_C > POOL2_OUTS) ? c_MAX_C : POOL2_OUTS;
    localparam int c_CNT_W = $clog2(c_MAX + 2);
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);
    localparam int c_FC_W  = 4;

    localparam logic [c_CNT_W-1:0] c_PIX_LAST  = c_CNT_W'(IMG_PIXELS - 1);
    localparam logic [c_CNT_W-1:0] c_CONV1_EXP = c_CNT_W'(CONV1_OUTS);
    localparam logic [c_CNT_W-1:0] c_POOL1_EXP = c_CNT_W'(POOL1_OUTS);
    localparam logic [c_CNT_W-1:0] c_CONV2_EXP = c_CNT_W'(CONV2_OUTS);
    localparam logic [c_CNT_W-1:0] c_POOL2_EXP = c_CNT_W'(POOL2_OUTS);
    localparam logic [c_WD_W-1:0]  c_TIMEOUT   = c_WD_W'(TIMEOUT);
    localparam logic [c_FC_W-1:0]  c_FC_LAST   = c_FC_W'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_CNT_W-1:0]         r_pix_cnt,   w_pix_nxt;
    logic [c_CNT_W-1:0]         r_conv1_cnt, w_conv1_nxt;
    logic [c_CNT_W-1:0]         r_pool1_cnt, w_pool1_nxt;
    logic [c_CNT_W-1:0]         r_conv2_cnt, w_conv2_nxt;
    logic [c_CNT_W-1:0]         r_pool2_cnt, w_pool2_nxt;
    logic [c_FC_W-1:0]          r_fc_cnt,    w_fc_nxt;
    logic [c_WD_W-1:0]          r_wd_cnt,    w_wd_nxt;
    logic signed [SCORE_W-1:0]  r_best_score, w_best_score_nxt;
    logic [3:0]                 r_best_idx,  w_best_idx_nxt;

    logic r_src_ready, r_pipe_clear, r_busy, r_valid_out, r_error;
    logic [3:0] r_prediction;

    logic w_fire, w_counting, w_any_strobe, w_match_cur, w_match_nxt;

    // Count a strobe unless the counter already sits one past its expected value.
    function automatic logic [c_CNT_W-1:0] f_sat_inc(
        input logic [c_CNT_W-1:0] cnt,
        input logic               strobe,
        input logic [c_CNT_W-1:0] expected
    );
        if (strobe && (cnt != expected + c_CNT_W'(1)))
            return cnt + c_CNT_W'(1);
        return cnt;
    endfunction

    assign w_fire       = src_valid & r_src_ready;
    assign pix_en       = w_fire;
    assign w_counting   = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_any_strobe = valid_out_conv1 | valid_out_maxpool1 | valid_out_conv2
                        | valid_out_maxpool2 | fc_valid;

    assign w_match_cur = (r_conv1_cnt == c_CONV1_EXP) && (r_pool1_cnt == c_POOL1_EXP)
                      && (r_conv2_cnt == c_CONV2_EXP) && (r_pool2_cnt == c_POOL2_EXP);
    assign w_match_nxt = (w_conv1_nxt == c_CONV1_EXP) && (w_pool1_nxt == c_POOL1_EXP)
                      && (w_conv2_nxt == c_CONV2_EXP) && (w_pool2_nxt == c_POOL2_EXP);

    // Next-state, counter, watchdog and argmax update logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_pix_nxt        = r_pix_cnt;
        w_conv1_nxt      = r_conv1_cnt;
        w_pool1_nxt      = r_pool1_cnt;
        w_conv2_nxt      = r_conv2_cnt;
        w_pool2_nxt      = r_pool2_cnt;
        w_fc_nxt         = r_fc_cnt;
        w_wd_nxt         = r_wd_cnt;
        w_best_score_nxt = r_best_score;
        w_best_idx_nxt   = r_best_idx;

        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_pix_nxt        = '0;
                w_conv1_nxt      = '0;
                w_pool1_nxt      = '0;
                w_conv2_nxt      = '0;
                w_pool2_nxt      = '0;
                w_fc_nxt         = '0;
                w_wd_nxt         = '0;
                w_best_score_nxt = '0;
                w_best_idx_nxt   = '0;
                w_state_nxt      = S_LOAD;
            end
            S_LOAD: begin
                if (w_fire) begin
                    w_pix_nxt = r_pix_cnt + c_CNT_W'(1);
                    if (r_pix_cnt == c_PIX_LAST)
                        w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_wd_nxt = w_any_strobe ? '0 : r_wd_cnt + c_WD_W'(1);
                if (w_wd_nxt == c_TIMEOUT)
                    w_state_nxt = S_ERROR;
            end
            S_DONE: begin
                w_state_nxt = w_match_cur ? S_IDLE : S_ERROR;
            end
            S_ERROR: begin
                if (start)
                    w_state_nxt = S_CLEAR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_counting) begin
            w_conv1_nxt = f_sat_inc(r_conv1_cnt, valid_out_conv1,    c_CONV1_EXP);
            w_pool1_nxt = f_sat_inc(r_pool1_cnt, valid_out_maxpool1, c_POOL1_EXP);
            w_conv2_nxt = f_sat_inc(r_conv2_cnt, valid_out_conv2,    c_CONV2_EXP);
            w_pool2_nxt = f_sat_inc(r_pool2_cnt, valid_out_maxpool2, c_POOL2_EXP);

            // Strict greater-than keeps the lowest index on ties; the last
            // score takes priority over a same-cycle watchdog expiry.
            if (fc_valid) begin
                if ((r_fc_cnt == '0) || ($signed(fc_score) > r_best_score)) begin
                    w_best_score_nxt = $signed(fc_score);
                    w_best_idx_nxt   = r_fc_cnt;
                end
                w_fc_nxt = r_fc_cnt + c_FC_W'(1);
                if (r_fc_cnt == c_FC_LAST)
                    w_state_nxt = S_DONE;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pix_cnt    <= '0;
            r_conv1_cnt  <= '0;
            r_pool1_cnt  <= '0;
            r_conv2_cnt  <= '0;
            r_pool2_cnt  <= '0;
            r_fc_cnt     <= '0;
            r_wd_cnt     <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_cnt    <= w_pix_nxt;
            r_conv1_cnt  <= w_conv1_nxt;
            r_pool1_cnt  <= w_pool1_nxt;
            r_conv2_cnt  <= w_conv2_nxt;
            r_pool2_cnt  <= w_pool2_nxt;
            r_fc_cnt     <= w_fc_nxt;
            r_wd_cnt     <= w_wd_nxt;
            r_best_score <= w_best_score_nxt;
            r_best_idx   <= w_best_idx_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it;
    // the prediction is committed on entry to DONE only for a clean frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_ready  <= 1'b0;
            r_pipe_clear <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_valid_out  <= 1'b0;
            r_prediction <= '0;
        end else begin
            r_src_ready  <= (w_state_nxt == S_LOAD);
            r_pipe_clear <= (w_state_nxt == S_CLEAR);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERROR);
            r_error      <= (w_state_nxt == S_ERROR);
            r_valid_out  <= (w_state_nxt == S_DONE) && w_match_nxt;
            if ((w_state_nxt == S_DONE) && w_match_nxt)
                r_prediction <= w_best_idx_nxt;
        end
    end

    assign src_ready  = r_src_ready;
    assign pipe_clear = r_pipe_clear;
    assign busy       = r_busy;
    assign error      = r_error;
    assign valid_out  = r_valid_out;
    assign prediction = r_prediction;

endmodule
`default_nettype wire

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Frame-level controller for the MNIST CNN pipeline (conv1 → maxpool1 → conv2 → maxpool2 → fc). It admits exactly one 28x28 image per frame from the upstream pixel source, clears the datapath line buffers between frames, and tracks each layer's valid pulses against the expected output counts. It runs a streaming argmax over the 10 fc class scores and emits the 4-bit prediction with a one-cycle `valid_out`. It sits between the top-level pixel input and the layer datapath, replacing free-running streaming with a sequenced, checked frame.

## Interface
Parameters:
- IMG_PIXELS, 784, pixels per frame
- CONV1_OUTS, 676, expected `valid_out_conv1` pulses per frame
- POOL1_OUTS, 169, expected `valid_out_maxpool1` pulses
- CONV2_OUTS, 121, expected `valid_out_conv2` pulses
- POOL2_OUTS, 25, expected `valid_out_maxpool2` pulses
- NUM_CLASSES, 10, fc scores per frame
- SCORE_W, 16, fc score width, signed two's complement
- TIMEOUT, 4096, idle-cycle watchdog limit in DRAIN

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new frame; sampled only in IDLE or ERROR
- src_valid  input  1  upstream pixel available
- src_ready  output  1  sequencer accepts pixel; fire = src_valid & src_ready
- pix_en  output  1  combinational copy of fire; advances the datapath
- pipe_clear  output  1  one-cycle pulse that clears datapath line buffers and window state
- valid_out_conv1, valid_out_maxpool1, valid_out_conv2, valid_out_maxpool2  input  1 each  layer output strobes
- fc_valid  input  1  one fc class score present
- fc_score  input  SCORE_W  signed score; class index is the arrival order, 0..9
- busy  output  1  high in every state except IDLE and ERROR
- prediction  output  4  argmax class; held until the next successful frame
- valid_out  output  1  one-cycle pulse when `prediction` updates
- error  output  1  held high in ERROR

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, DONE, ERROR.
- IDLE: src_ready=0. start → CLEAR.
- CLEAR (1 cycle): pipe_clear=1. Zero all counters, best_score, best_idx and the watchdog. Clear error. Go to LOAD.
- LOAD: src_ready=1. Each fire increments pix_cnt. A fire with pix_cnt==IMG_PIXELS-1 → DRAIN.
- DRAIN: src_ready=0. The watchdog increments each cycle and resets on any layer strobe or fc_valid. Watchdog reaching TIMEOUT → ERROR.
- Layer counters: count their strobes in LOAD and DRAIN and saturate at their expected value plus one. Strobes in other states are ignored.
- fc handling (LOAD or DRAIN): on fc_valid, idx = fc_cnt.
  - idx 0 loads best_score/best_idx unconditionally.
  - Later scores replace only when strictly greater (signed compare), so ties resolve to the lowest index.
  - The NUM_CLASSES-th score → DONE.
- DONE (1 cycle): all four layer counters must equal their expected values.
  - If they match: prediction ← best_idx, valid_out=1, → IDLE.
  - If not: prediction unchanged, valid_out=0, → ERROR.
- ERROR: error=1, src_ready=0. start → CLEAR. Other inputs are ignored.
- start in CLEAR, LOAD, DRAIN or DONE is ignored; no queuing.
- Same-cycle 10th fc_valid and watchdog expiry: the score wins and the FSM goes to DONE.
- fc_valid beyond NUM_CLASSES cannot occur, because the FSM leaves DRAIN on the 10th score.

## Timing
- Reset values: src_ready=0, pix_en=0, pipe_clear=0, busy=0, prediction=0, valid_out=0, error=0, state=IDLE, all counters 0.
- rst asserted in any state returns to IDLE on the next edge. A partially loaded frame is abandoned with no valid_out.
- start high at edge t: CLEAR during cycle t+1 (pipe_clear=1, busy=1), LOAD from t+2 (src_ready=1).
- Minimum LOAD time is IMG_PIXELS cycles with src_valid held high.
- 10th fc_valid at edge t: DONE during t+1, valid_out=1 and new prediction visible in t+1, IDLE at t+2.
- A back-to-back frame needs start at t+2 at the earliest.
- All outputs are registered except pix_en.

## Test plan
- Nominal frame: start, 784 pixels with src_valid always high, model strobes 676/169/121/25, fc scores {3,-5,9,9,2,0,-1,7,8,1} → valid_out one cycle after the 10th score, prediction=2 (tie resolves to the lower index), error=0.
- Backpressure and gaps: src_valid toggles 50% → exactly 784 fires; src_ready drops the cycle after the 784th fire; pix_en never high outside LOAD.
- Count mismatch: only 24 maxpool2 strobes → DONE → ERROR, error=1, valid_out stays 0, prediction keeps its previous value. A following start clears error and a good frame completes.
- Watchdog: stop all strobes after the 5th fc score → ERROR exactly TIMEOUT cycles after the last strobe. With the 10th score coincident with expiry → DONE instead.
- Reset mid-LOAD after 300 pixels → IDLE next cycle, all outputs at reset values. A new start gives pipe_clear, then a full 784-pixel load.
- start pulses during LOAD/DRAIN are ignored; all-negative scores {-9,-3,-3,…} → prediction=1.
